// File: rtl/bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_responder
// Brief    : Single-port 32 x 64-bit memory slave that answers bus cycles
//            after a configurable number of wait states. A request is latched
//            in IDLE, optionally held in WAIT, and answered for one cycle in
//            ACK. Reads return the full stored word; writes update only the
//            selected byte lanes at the end of the ACK cycle.
// Options  : `define BUS_ERR_EN adds err_o. Misses and instruction-fetch
//            (vpa_i) writes then answer with err_o instead of ack_o.
// Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
  parameter logic [63:0] BASE_ADR    = 64'hE000_0000_0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:3] adr_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [7:0]  sel_i,
  input  logic        we_i,
  input  logic        vpa_i,
  input  logic [63:0] dat_i,
`ifdef BUS_ERR_EN
  output logic        err_o,
`endif
  output logic        ack_o,
  output logic [63:0] dat_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [63:0] dat_q, dat_d;
`ifdef BUS_ERR_EN
  logic        err_q, err_d;
`endif

  // Request captured in IDLE; held for the rest of the transfer.
  logic [4:0]  idx_q;
  logic [7:0]  sel_q;
  logic        we_q;
  logic        hit_q;
  logic        vpa_q;
  logic [63:0] wdat_q;

  logic [63:0] mem_q [0:31];

  logic        w_req;
  logic        w_hit;
  logic [4:0]  w_rsp_idx;
  logic        w_rsp_we;
  logic        w_rsp_hit;
  logic        w_rsp_vpa;
  logic        w_err;

  assign w_req = cyc_i & stb_i;
  assign w_hit = (adr_i[63:8] == BASE_ADR[63:8]);

  // With zero wait states the response is computed in the same cycle the
  // request is latched, so the live inputs stand in for the latched copy.
  assign w_rsp_idx = (state_q == ST_IDLE) ? adr_i[7:3] : idx_q;
  assign w_rsp_we  = (state_q == ST_IDLE) ? we_i       : we_q;
  assign w_rsp_hit = (state_q == ST_IDLE) ? w_hit      : hit_q;
  assign w_rsp_vpa = (state_q == ST_IDLE) ? vpa_i      : vpa_q;

  // Error response only exists with the error option; constant 0 otherwise.
  assign w_err = ERR_EN & (~w_rsp_hit | (w_rsp_we & w_rsp_vpa));

  // Next-state, wait counter and registered response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = 64'd0;
`ifdef BUS_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // An abort wins over the final countdown step.
        if (!w_req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (state_d == ST_ACK) begin
      if (w_err) begin
`ifdef BUS_ERR_EN
        err_d = 1'b1;
`endif
      end else begin
        ack_d = 1'b1;
        if (!w_rsp_we && w_rsp_hit) begin
          dat_d = mem_q[w_rsp_idx];
        end
      end
    end
  end

  // Control and response registers; reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= 64'd0;
`ifdef BUS_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
`ifdef BUS_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Latch the request attributes when a new cycle is accepted.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == ST_IDLE) && w_req) begin
      idx_q  <= adr_i[7:3];
      sel_q  <= sel_i;
      we_q   <= we_i;
      hit_q  <= w_hit;
      vpa_q  <= vpa_i;
      wdat_q <= dat_i;
    end
  end

  // Commit write data at the end of the ACK cycle unless reset cancels it.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == ST_ACK) && we_q && hit_q && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
        end
      end
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
`ifdef BUS_ERR_EN
  assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter BASE_ADR, default 64'hE000_0000_0000_0000, 256-byte window base; bits [7:0] ignored.
REQ-002 Parameter WAIT_STATES, default 1, wait cycles inserted before acknowledge (legal 0..15).
REQ-003 clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 adr_i  in  61  doubleword address [63:3].
REQ-006 cyc_i  in  1  bus cycle in progress.
REQ-007 stb_i  in  1  transfer strobe.
REQ-008 sel_i  in  8  byte-lane selects; bit n enables dat bits [8n+7:8n].
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 vpa_i  in  1  instruction-fetch qualifier.
REQ-011 dat_i  in  64  write data from initiator.
REQ-012 ack_o  out  1  transfer acknowledge, registered.
REQ-013 dat_o  out  64  read data, registered.
REQ-014 err_o  out  1  error acknowledge; present only with BUS_ERR_EN.

Function
REQ-015 Storage: 32 x 64-bit words indexed by adr_i[7:3].
REQ-016 Hit: adr_i[63:8] == BASE_ADR[63:8]; otherwise miss.
REQ-017 States: IDLE, WAIT, ACK.
- IDLE: cyc_i & stb_i sampled high -> latch adr_i, sel_i, we_i, dat_i, hit, vpa_i; go to WAIT loading counter with WAIT_STATES, or directly to ACK if WAIT_STATES == 0.
- WAIT: decrement counter each cycle; go to ACK after counter reaches 0.
- ACK: drive response for exactly one cycle; return to IDLE.
REQ-018 Latency: a request sampled in cycle N is acknowledged in cycle N+1+WAIT_STATES.
REQ-019 ack_o is high only in ACK and only for one cycle per transfer.
REQ-020 Minimum two cycles per transfer. A strobe still high in the cycle after ACK is sampled as a new request.
REQ-021 Read hit: dat_o = stored word, all 64 bits regardless of sel_i, valid while ack_o is high.
REQ-022 Write hit: update only selected bytes at the ACK edge; dat_o = 0.
REQ-023 sel_i == 0 write: no change, still acknowledged.
REQ-024 Abort: cyc_i or stb_i low while in WAIT -> return to IDLE, no ack, no write.
REQ-025 Miss without BUS_ERR_EN: ack_o pulses, dat_o = 0, writes discarded.
REQ-026 dat_o returns to 0 in every non-ACK cycle.
REQ-027 vpa_i has no effect without BUS_ERR_EN.

Reset
REQ-028 While reset_i is sampled high: state = IDLE, ack_o = 0, dat_o = 0, err_o = 0, counter = 0.
REQ-029 Reset mid-transfer (WAIT or ACK) cancels it; no ack follows and no pending write completes.
REQ-030 Memory contents are not cleared by reset.
REQ-031 reset_i has priority over all other inputs.

Configuration
REQ-032 Macro BUS_ERR_EN, when defined:
- err_o exists.
- A miss, or a write with latched vpa_i = 1, pulses err_o in the ACK slot instead of ack_o, with dat_o = 0 and no write.
- ack_o and err_o are never high together.
REQ-033 Macro BUS_ERR_EN undefined: no err_o port; misses follow REQ-025; vpa_i writes behave as ordinary writes.

Verification
REQ-034 Reset: hold reset_i 1 for 2 cycles with stb_i = 1 -> ack_o = 0, dat_o = 0 throughout; first ack occurs 2 cycles after release (WAIT_STATES = 1).
REQ-035 Write then read:
- write 64'h0123_4567_89AB_CDEF, sel 8'hFF, adr E000_0000_0000_0018 -> ack_o in cycle N+2.
- read same adr -> dat_o = 64'h0123_4567_89AB_CDEF with ack_o.
REQ-036 Byte lanes: then write 64'h4141_4141_4141_4141, sel 8'b0000_0010 -> read returns 64'h0123_4567_89AB_41EF.
REQ-037 Abort and reset mid-transfer:
- drop stb_i in WAIT of a write of 64'hFFFF..., sel 8'hFF -> no ack; later read unchanged.
- repeat with reset_i in WAIT -> same result.
REQ-038 Miss: read adr 64'h0000_0000_1111_1110:
- without BUS_ERR_EN -> ack_o = 1, dat_o = 0.
- with BUS_ERR_EN -> err_o = 1, ack_o = 0.
- with BUS_ERR_EN, write hit with vpa_i = 1 -> err_o = 1, memory unchanged.
REQ-039 Back-to-back: stb_i held high for 6 reads, WAIT_STATES = 0 -> ack_o toggles 1,0,1,0,1,0, one ack per transfer.
